// File: rtl/sync_ram_pkg.sv
// Shared types and helpers for the multi-read-port synchronous RAM.
package sync_ram_pkg;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } ram_state_e;

   typedef enum logic {
      RDW_OLD = 1'b0,
      RDW_NEW = 1'b1
   } rdw_mode_e;

   // Address width for a given depth, never below one bit.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sync_ram_rd_port.sv
// One read port: range check, read-during-write mux, capture register and
// optional output pipeline stage.
module sync_ram_rd_port
   import sync_ram_pkg::*;
#(
   parameter int WIDTH_P    = 32,
   parameter int DEPTH_P    = 128,
   parameter int AW_P       = 7,
   parameter int RDW_MODE_P = 0,
   parameter int OUT_REG_P  = 0
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               rd_en_i,
   input  logic [AW_P-1:0]    rd_addr_i,
   input  logic [WIDTH_P-1:0] mem_word_i,
   input  logic               wr_en_i,
   input  logic [AW_P-1:0]    wr_addr_i,
   input  logic [WIDTH_P-1:0] wr_data_i,
   output logic [WIDTH_P-1:0] data_o,
   output logic               valid_o
);

   localparam rdw_mode_e RDW_MODE = (RDW_MODE_P == 1) ? RDW_NEW : RDW_OLD;

   logic               in_range;
   logic               collide;
   logic [WIDTH_P-1:0] rd_word;
   logic [WIDTH_P-1:0] cap_data_q, cap_data_d;
   logic               cap_valid_q, cap_valid_d;

   // NOTE: combinational blocks use blocking '=' and assign every output a
   // default first, so no latch is inferred; clocked blocks use '<=' only.
   always_comb begin
      in_range = 32'(rd_addr_i) < 32'(DEPTH_P);
      collide  = wr_en_i && (wr_addr_i == rd_addr_i);
      rd_word  = '0;
      if (in_range) begin
         rd_word = (RDW_MODE == RDW_NEW && collide) ? wr_data_i : mem_word_i;
      end
   end

   always_comb begin
      cap_data_d  = cap_data_q;
      cap_valid_d = 1'b0;
      if (rd_en_i) begin
         cap_data_d  = rd_word;
         cap_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cap_data_q  <= '0;
         cap_valid_q <= 1'b0;
      end else begin
         cap_data_q  <= cap_data_d;
         cap_valid_q <= cap_valid_d;
      end
   end

   if (OUT_REG_P != 0) begin : g_out_reg
      logic [WIDTH_P-1:0] out_data_q;
      logic               out_valid_q;

      // Runs every cycle so reads already in flight always complete.
      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
         end else begin
            out_data_q  <= cap_data_q;
            out_valid_q <= cap_valid_q;
         end
      end

      assign data_o  = out_data_q;
      assign valid_o = out_valid_q;
   end else begin : g_no_out_reg
      assign data_o  = cap_data_q;
      assign valid_o = cap_valid_q;
   end

endmodule

// File: rtl/sync_ram_nrd.sv
// Synchronous RAM with one write port, RD_PORTS_P read ports and a hardware
// clear sweep that initialises the array after reset or on request.
module sync_ram_nrd
   import sync_ram_pkg::*;
#(
   parameter int                 WIDTH_P          = 32,
   parameter int                 DEPTH_P          = 128,
   parameter int                 RD_PORTS_P       = 3,
   parameter int                 RDW_MODE_P       = 0,
   parameter int                 OUT_REG_P        = 0,
   parameter int                 CLEAR_ON_RESET_P = 1,
   parameter logic [WIDTH_P-1:0] INIT_VAL_P       = '0,
   localparam int                AW               = clog2_min1(DEPTH_P)
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic                                clear_i,
   output logic                                ready_o,
   input  logic                                wr_en_i,
   input  logic [AW-1:0]                       wr_addr_i,
   input  logic [WIDTH_P-1:0]                  data_i,
   input  logic [RD_PORTS_P-1:0]               rd_en_i,
   input  logic [RD_PORTS_P-1:0][AW-1:0]       rd_addr_i,
   output logic [RD_PORTS_P-1:0][WIDTH_P-1:0]  data_o,
   output logic [RD_PORTS_P-1:0]               valid_o
);

   localparam ram_state_e    RESET_STATE = (CLEAR_ON_RESET_P != 0) ? ST_CLEAR : ST_READY;
   localparam logic [AW-1:0] LAST_ADDR   = AW'(DEPTH_P - 1);

   ram_state_e         state_q, state_d;
   logic [AW-1:0]      cnt_q, cnt_d;
   logic               sweep_we;
   logic               op_en;
   logic               wr_fire;
   logic [WIDTH_P-1:0] mem_q [DEPTH_P];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= RESET_STATE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_CLEAR: begin
            if (cnt_q == LAST_ADDR) begin
               state_d = ST_READY;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_READY: begin
            if (clear_i) begin
               state_d = ST_CLEAR;
               cnt_d   = '0;
            end
         end
         default: state_d = RESET_STATE;
      endcase
   end

   // A clear request also blocks the write and reads presented with it.
   always_comb begin
      ready_o  = (state_q == ST_READY);
      sweep_we = (state_q == ST_CLEAR);
      op_en    = ready_o && !clear_i;
      wr_fire  = op_en && wr_en_i && (32'(wr_addr_i) < 32'(DEPTH_P));
   end

   // NOTE: the array has no reset branch so it maps onto RAM macros; the
   // clear sweep is the only way its contents get initialised.
   always_ff @(posedge clk_i) begin
      if (sweep_we) begin
         mem_q[cnt_q] <= INIT_VAL_P;
      end else if (wr_fire) begin
         mem_q[wr_addr_i] <= data_i;
      end
   end

   for (genvar p = 0; p < RD_PORTS_P; p++) begin : g_rd
      logic [AW-1:0] rd_idx;

      // Keeps the array index legal; the port itself zeroes out-of-range data.
      assign rd_idx = (32'(rd_addr_i[p]) < 32'(DEPTH_P)) ? rd_addr_i[p] : '0;

      sync_ram_rd_port #(
         .WIDTH_P    (WIDTH_P),
         .DEPTH_P    (DEPTH_P),
         .AW_P       (AW),
         .RDW_MODE_P (RDW_MODE_P),
         .OUT_REG_P  (OUT_REG_P)
      ) u_rd_port (
         .clk_i      (clk_i),
         .rst_i      (rst_i),
         .rd_en_i    (op_en && rd_en_i[p]),
         .rd_addr_i  (rd_addr_i[p]),
         .mem_word_i (mem_q[rd_idx]),
         .wr_en_i    (wr_fire),
         .wr_addr_i  (wr_addr_i),
         .wr_data_i  (data_i),
         .data_o     (data_o[p]),
         .valid_o    (valid_o[p])
      );
   end

endmodule
